// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: N_RW byte-strobed control registers,
// N_RO read-only status registers, and one-cycle write pulses toward the pipeline.
module axi_lite_regfile #(
    parameter int                 AXI_LITE_ADDR_WIDTH = 8,
    parameter int                 N_RW                = 8,
    parameter int                 N_RO                = 4,
    parameter logic [N_RW*32-1:0] RESET_VAL           = {N_RW{32'h0}}
) (
    input  logic                           s_axi_lite_aclk,
    input  logic                           axi_reset,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_awaddr,
    input  logic                           s_axi_lite_awvalid,
    output logic                           s_axi_lite_awready,
    input  logic [31:0]                    s_axi_lite_wdata,
    input  logic [3:0]                     s_axi_lite_wstrb,
    input  logic                           s_axi_lite_wvalid,
    output logic                           s_axi_lite_wready,
    output logic [1:0]                     s_axi_lite_bresp,
    output logic                           s_axi_lite_bvalid,
    input  logic                           s_axi_lite_bready,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_araddr,
    input  logic                           s_axi_lite_arvalid,
    output logic                           s_axi_lite_arready,
    output logic [31:0]                    s_axi_lite_rdata,
    output logic [1:0]                     s_axi_lite_rresp,
    output logic                           s_axi_lite_rvalid,
    input  logic                           s_axi_lite_rready,
    output logic [N_RW*32-1:0]             rw_regs,
    input  logic [N_RO*32-1:0]             ro_regs,
    output logic [N_RW-1:0]                wr_pulse
);

    localparam int         IW          = AXI_LITE_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {W_IDLE, W_DATA, W_ADDR, W_WRITE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    w_state_t    w_state;
    r_state_t    r_state;
    logic [IW-1:0] w_idx;
    logic [31:0]   w_data;
    logic [3:0]    w_strb;
    logic [IW-1:0] r_idx;
    logic          w_hit;
    logic [31:0]   r_word;
    logic [1:0]    r_resp;

    // Byte-offset bits carry no meaning in a word-addressed register map.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

    // Full-width index compare: an out-of-range index never aliases onto a register.
    always_comb begin
        w_hit = 1'b0;
        for (int unsigned i = 0; i < N_RW; i++)
            if (w_idx == IW'(i)) w_hit = 1'b1;
    end

    always_comb begin
        r_word = '0;
        r_resp = RESP_SLVERR;
        for (int unsigned i = 0; i < N_RW; i++)
            if (r_idx == IW'(i)) begin
                r_word = rw_regs[32*i +: 32];
                r_resp = RESP_OKAY;
            end
        for (int unsigned j = 0; j < N_RO; j++)
            if (r_idx == IW'(N_RW + j)) begin
                r_word = ro_regs[32*j +: 32];
                r_resp = RESP_OKAY;
            end
    end

    always_ff @(posedge s_axi_lite_aclk) begin
        if (axi_reset) begin
            w_state            <= W_IDLE;
            s_axi_lite_awready <= 1'b1;
            s_axi_lite_wready  <= 1'b1;
            s_axi_lite_bvalid  <= 1'b0;
            s_axi_lite_bresp   <= RESP_OKAY;
            wr_pulse           <= '0;
            rw_regs            <= RESET_VAL;
            w_idx              <= '0;
            w_data             <= '0;
            w_strb             <= '0;
        end else begin
            wr_pulse <= '0;
            case (w_state)
                W_IDLE: begin
                    if (s_axi_lite_awvalid) w_idx <= s_axi_lite_awaddr[AXI_LITE_ADDR_WIDTH-1:2];
                    if (s_axi_lite_wvalid) begin
                        w_data <= s_axi_lite_wdata;
                        w_strb <= s_axi_lite_wstrb;
                    end
                    if (s_axi_lite_awvalid && s_axi_lite_wvalid) begin
                        w_state            <= W_WRITE;
                        s_axi_lite_awready <= 1'b0;
                        s_axi_lite_wready  <= 1'b0;
                    end else if (s_axi_lite_awvalid) begin
                        w_state            <= W_DATA;
                        s_axi_lite_awready <= 1'b0;
                    end else if (s_axi_lite_wvalid) begin
                        w_state           <= W_ADDR;
                        s_axi_lite_wready <= 1'b0;
                    end
                end
                W_DATA: begin
                    if (s_axi_lite_wvalid) begin
                        w_data            <= s_axi_lite_wdata;
                        w_strb            <= s_axi_lite_wstrb;
                        w_state           <= W_WRITE;
                        s_axi_lite_wready <= 1'b0;
                    end
                end
                W_ADDR: begin
                    if (s_axi_lite_awvalid) begin
                        w_idx              <= s_axi_lite_awaddr[AXI_LITE_ADDR_WIDTH-1:2];
                        w_state            <= W_WRITE;
                        s_axi_lite_awready <= 1'b0;
                    end
                end
                W_WRITE: begin
                    for (int unsigned i = 0; i < N_RW; i++)
                        if (w_idx == IW'(i)) begin
                            for (int unsigned k = 0; k < 4; k++)
                                if (w_strb[k]) rw_regs[32*i + 8*k +: 8] <= w_data[8*k +: 8];
                            wr_pulse[i] <= 1'b1;
                        end
                    s_axi_lite_bresp  <= w_hit ? RESP_OKAY : RESP_SLVERR;
                    s_axi_lite_bvalid <= 1'b1;
                    w_state           <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi_lite_bready) begin
                        s_axi_lite_bvalid  <= 1'b0;
                        s_axi_lite_awready <= 1'b1;
                        s_axi_lite_wready  <= 1'b1;
                        w_state            <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_lite_aclk) begin
        if (axi_reset) begin
            r_state            <= R_IDLE;
            s_axi_lite_arready <= 1'b1;
            s_axi_lite_rvalid  <= 1'b0;
            s_axi_lite_rdata   <= '0;
            s_axi_lite_rresp   <= RESP_OKAY;
            r_idx              <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_lite_arvalid) begin
                        r_idx              <= s_axi_lite_araddr[AXI_LITE_ADDR_WIDTH-1:2];
                        s_axi_lite_arready <= 1'b0;
                        r_state            <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    s_axi_lite_rdata  <= r_word;
                    s_axi_lite_rresp  <= r_resp;
                    s_axi_lite_rvalid <= 1'b1;
                    r_state           <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi_lite_rready) begin
                        s_axi_lite_rvalid  <= 1'b0;
                        s_axi_lite_arready <= 1'b1;
                        r_state            <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: vector table of single writes/reads plus
// hand-written staggered, back-pressure, concurrent and reset-mid-write sequences.
module tb_axi_lite_regfile;

    localparam int NRW = 8;
    localparam int NRO = 4;
    localparam logic [NRW*32-1:0] RV = {{5{32'h0}}, 32'hA5A5_0000, {2{32'h0}}};

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       awaddr, araddr;
    logic             awvalid, awready, wvalid, wready, bvalid, bready;
    logic             arvalid, arready, rvalid, rready;
    logic [31:0]      wdata, rdata;
    logic [3:0]       wstrb;
    logic [1:0]       bresp, rresp;
    logic [NRW*32-1:0] rw_regs;
    logic [NRO*32-1:0] ro_regs;
    logic [NRW-1:0]   wr_pulse;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_regs [NRW];

    axi_lite_regfile #(
        .AXI_LITE_ADDR_WIDTH(8),
        .N_RW(NRW),
        .N_RO(NRO),
        .RESET_VAL(RV)
    ) dut (
        .s_axi_lite_aclk(clk), .axi_reset(rst),
        .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
        .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid),
        .s_axi_lite_wready(wready), .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid),
        .s_axi_lite_bready(bready), .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid),
        .s_axi_lite_arready(arready), .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
        .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready),
        .rw_regs(rw_regs), .ro_regs(ro_regs), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] exp;   // write: register value afterwards; read: rdata
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [NRW*32-1:0] pack_exp();
        logic [NRW*32-1:0] v;
        for (int i = 0; i < NRW; i++) v[32*i +: 32] = exp_regs[i];
        return v;
    endfunction

    task automatic load_reset_exp();
        for (int i = 0; i < NRW; i++) exp_regs[i] = RV[32*i +: 32];
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] er, input logic [NRW-1:0] ep, input string tag);
        @(negedge clk);
        chk({tag, " awready"}, 256'(awready), 256'(1));
        chk({tag, " wready"}, 256'(wready), 256'(1));
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk({tag, " bvalid c1"}, 256'(bvalid), 256'(0));
        chk({tag, " pulse c1"}, 256'(wr_pulse), 256'(0));
        @(negedge clk);
        chk({tag, " bvalid c2"}, 256'(bvalid), 256'(1));
        chk({tag, " bresp"}, 256'(bresp), 256'(er));
        chk({tag, " pulse c2"}, 256'(wr_pulse), 256'(ep));
        chk({tag, " rw_regs"}, 256'(rw_regs), 256'(pack_exp()));
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk({tag, " bvalid c3"}, 256'(bvalid), 256'(0));
        chk({tag, " pulse c3"}, 256'(wr_pulse), 256'(0));
    endtask

    task automatic do_read(input logic [7:0] a, input logic [1:0] er, input logic [31:0] ed,
                           input string tag);
        @(negedge clk);
        chk({tag, " arready"}, 256'(arready), 256'(1));
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk({tag, " rvalid c1"}, 256'(rvalid), 256'(0));
        @(negedge clk);
        chk({tag, " rvalid c2"}, 256'(rvalid), 256'(1));
        chk({tag, " rdata"}, 256'(rdata), 256'(ed));
        chk({tag, " rresp"}, 256'(rresp), 256'(er));
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk({tag, " rvalid c3"}, 256'(rvalid), 256'(0));
        chk({tag, " arready c3"}, 256'(arready), 256'(1));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h04, 32'h1234_5678, 4'b1111, 2'b00, 32'h1234_5678};
        vecs[1]  = '{1'b1, 8'h08, 32'h0000_BEEF, 4'b0011, 2'b00, 32'hA5A5_BEEF};
        vecs[2]  = '{1'b1, 8'h08, 32'h1122_3344, 4'b1000, 2'b00, 32'h11A5_BEEF};
        vecs[3]  = '{1'b1, 8'h1C, 32'hDEAD_BEEF, 4'b1111, 2'b00, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 8'h0C, 32'hFFFF_FFFF, 4'b0000, 2'b00, 32'h0000_0000};
        vecs[5]  = '{1'b1, 8'h20, 32'h5555_5555, 4'b1111, 2'b10, 32'h0};
        vecs[6]  = '{1'b1, 8'h40, 32'h6666_6666, 4'b1111, 2'b10, 32'h0};
        vecs[7]  = '{1'b1, 8'h3D, 32'h7777_7777, 4'b1111, 2'b10, 32'h0};
        vecs[8]  = '{1'b1, 8'h84, 32'h8888_8888, 4'b1111, 2'b10, 32'h0};
        vecs[9]  = '{1'b1, 8'h07, 32'hAAAA_5555, 4'b1111, 2'b00, 32'hAAAA_5555};
        vecs[10] = '{1'b0, 8'h04, 32'h0, 4'b0, 2'b00, 32'hAAAA_5555};
        vecs[11] = '{1'b0, 8'h08, 32'h0, 4'b0, 2'b00, 32'h11A5_BEEF};
        vecs[12] = '{1'b0, 8'h24, 32'h0, 4'b0, 2'b00, 32'h0000_CAFE};
        vecs[13] = '{1'b0, 8'h20, 32'h0, 4'b0, 2'b00, 32'h1111_0000};
        vecs[14] = '{1'b0, 8'h2C, 32'h0, 4'b0, 2'b00, 32'h3333_3333};
        vecs[15] = '{1'b0, 8'h30, 32'h0, 4'b0, 2'b10, 32'h0};
        vecs[16] = '{1'b0, 8'h40, 32'h0, 4'b0, 2'b10, 32'h0};
        vecs[17] = '{1'b0, 8'h0C, 32'h0, 4'b0, 2'b00, 32'h0};
        vecs[18] = '{1'b0, 8'h84, 32'h0, 4'b0, 2'b10, 32'h0};

        ro_regs = {32'h3333_3333, 32'h2222_2222, 32'h0000_CAFE, 32'h1111_0000};
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        load_reset_exp();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("reset rw_regs", 256'(rw_regs), 256'(RV));
        chk("reset ready", 256'({awready, wready, arready}), 256'(3'b111));
        chk("reset valid", 256'({bvalid, rvalid}), 256'(2'b00));
        chk("reset resp", 256'({bresp, rresp}), 256'(4'b0000));
        chk("reset rdata", 256'(rdata), 256'(0));
        chk("reset pulse", 256'(wr_pulse), 256'(0));

        for (int v = 0; v < 19; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            if (vecs[v].is_wr) begin
                int idx;
                logic [NRW-1:0] ep;
                idx = int'(vecs[v].addr >> 2);
                ep = '0;
                if (vecs[v].resp == 2'b00) begin
                    exp_regs[idx] = vecs[v].exp;
                    ep[idx] = 1'b1;
                end
                do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].resp, ep, tag);
            end else begin
                do_read(vecs[v].addr, vecs[v].resp, vecs[v].exp, tag);
            end
        end

        // Staggered: address in cycle 0, data in cycle 3, response in cycle 5.
        @(negedge clk);
        awaddr = 8'h14; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        chk("stag awready c1", 256'(awready), 256'(0));
        chk("stag wready c1", 256'(wready), 256'(1));
        @(negedge clk);
        chk("stag bvalid c2", 256'(bvalid), 256'(0));
        @(negedge clk);
        wdata = 32'hFFFF_FFFF; wstrb = 4'b0101; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        chk("stag bvalid c4", 256'(bvalid), 256'(0));
        chk("stag reg5 c4", 256'(rw_regs[32*5 +: 32]), 256'(0));
        @(negedge clk);
        exp_regs[5] = 32'h00FF_00FF;
        chk("stag bvalid c5", 256'(bvalid), 256'(1));
        chk("stag bresp", 256'(bresp), 256'(0));
        chk("stag rw_regs", 256'(rw_regs), 256'(pack_exp()));
        chk("stag pulse", 256'(wr_pulse), 256'(8'h20));
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("stag pulse c6", 256'(wr_pulse), 256'(0));
        chk("stag bvalid c6", 256'(bvalid), 256'(0));

        // Read back-pressure: rready low for 5 cycles.
        @(negedge clk);
        araddr = 8'h1C; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold rvalid %0d", c), 256'(rvalid), 256'(1));
            chk($sformatf("hold rdata %0d", c), 256'(rdata), 256'(32'hDEAD_BEEF));
            chk($sformatf("hold arready %0d", c), 256'(arready), 256'(0));
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("hold done", 256'({arready, rvalid}), 256'(2'b10));

        // Read and write of reg4 with R_FETCH on the commit edge: read sees old value.
        @(negedge clk);
        awaddr = 8'h10; araddr = 8'h10; wdata = 32'h5566_7788; wstrb = 4'b1111;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        exp_regs[4] = 32'h5566_7788;
        chk("conc rdata old", 256'(rdata), 256'(0));
        chk("conc rvalid", 256'(rvalid), 256'(1));
        chk("conc bvalid", 256'(bvalid), 256'(1));
        chk("conc rw_regs", 256'(rw_regs), 256'(pack_exp()));
        chk("conc pulse", 256'(wr_pulse), 256'(8'h10));
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        chk("conc done", 256'({rvalid, bvalid}), 256'(2'b00));

        // Reset asserted while the write is in W_WRITE.
        @(negedge clk);
        awaddr = 8'h08; wdata = 32'h1234_5678; wstrb = 4'b1111; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load_reset_exp();
        chk("rstw rw_regs", 256'(rw_regs), 256'(RV));
        chk("rstw pulse", 256'(wr_pulse), 256'(0));
        chk("rstw bvalid", 256'(bvalid), 256'(0));
        chk("rstw ready", 256'({awready, wready, arready}), 256'(3'b111));
        @(negedge clk);
        chk("rstw pulse c3", 256'(wr_pulse), 256'(0));
        chk("rstw bvalid c3", 256'(bvalid), 256'(0));
        exp_regs[2] = 32'hA5A5_00C3;
        do_write(8'h08, 32'hFFFF_FFC3, 4'b0001, 2'b00, 8'h04, "post-reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
